fp_operand_align_32bit: RTL and testbench
=========================================

Name: fp_operand_align_32bit

Overview:
- Front end of the FP arithmetic path. Takes two raw IEEE-754 single-precision operands and produces the 28-bit extended-mantissa format the normalize/round stage consumes: [27] carry headroom, [26:3] hidden bit plus 23-bit fraction, [2] guard, [1] round, [0] sticky.
- Unpacks and classifies both operands. For ADD/SUB it swaps them so A has the larger magnitude, then right-aligns B to A's exponent with sticky collection.
- 2-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- SHIFT_SAT, 27, alignment distance at or above which B collapses entirely into the sticky bit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- op_a  in  32  IEEE-754 operand A
- op_b  in  32  IEEE-754 operand B
- alu_op  in  5  00001 ADD, 00010 SUB, 00011 MUL, 00100 DIV, 00101 SQRT, 01110 CONV
- rm  in  3  rounding mode, carried through unchanged
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- out_sign_a, out_sign_b  out  1 each  signs after SUB negation and swap
- out_exp  out  8  common (larger) biased exponent
- out_mant_a, out_mant_b  out  28 each  extended mantissas
- out_class_a, out_class_b  out  4 each  one-hot {nan, inf, zero, subnormal}; all-zero means normal
- out_swapped  out  1  operands were exchanged
- out_eff_sub  out  1  effective subtraction (sign_a XOR sign_b, ADD/SUB only)
- out_alu_op  out  5  carried through
- out_rm  out  3  carried through

Behaviour:
- Reset (asynchronous, active-high): both stage valid bits clear; out_valid=0; every data output 0. in_ready=1 once rst deasserts. Reset mid-flight discards in-flight pairs and produces no partial output.
- Handshake:
  - Transfer on in_valid & in_ready, and on out_valid & out_ready.
  - s2_free = ~s2_valid | out_ready.
  - s1_free = ~s1_valid | s2_free.
  - in_ready = s1_free.
  - Latency is exactly 2 cycles with no stalls; throughput 1 pair/cycle.
  - Outputs hold stable while out_valid & ~out_ready.
- Stage 1 (unpack, classify, swap):
  - exp=0xFF with frac≠0 → nan. exp=0xFF with frac=0 → inf. exp=0 with frac=0 → zero. exp=0 with frac≠0 → subnormal.
  - Hidden bit = (exp≠0). A subnormal's effective exponent is 1.
  - SUB inverts sign_b before swapping.
  - For ADD/SUB: swap when {exp_b, frac_b} > {exp_a, frac_a}. Equal magnitudes do not swap.
- Stage 2 (align):
  - mant = {1'b0, hidden, frac, 3'b000}.
  - d = exp_a_eff − exp_b_eff.
  - d < SHIFT_SAT: mant_b shifts right by d. Bit [0] = OR of all bits shifted out, ORed with the original bit 0.
  - d ≥ SHIFT_SAT: mant_b = 28'h0000001 if B is nonzero, else 0.
  - out_exp = exp_a_eff.
- Non-ADD/SUB ops: no swap, no shift. out_exp = exp_a (raw). Both mantissas are unshifted. eff_sub=0.
- Special operands (nan/inf) still pass through the alignment path; the class flags are authoritative for downstream.

Optional Feature:
- Macro FP_ALIGN_FTZ_EN.
- Defined: a subnormal input is flushed to a signed zero in stage 1. Hidden bit=0, frac=0, class=zero; the subnormal class bit is never set.
- Undefined: subnormals pass through as described above.

Decomposition:
- Shared package fp_pkg:
  - alu_op encodings (FP_ADD, FP_SUB, FP_MUL, FP_DIV, FP_SQRT, FP_CONV)
  - rounding-mode encodings (RNE, RTZ, RDN, RUP, RMM)
  - class one-hot bit indices
  - the 28-bit extended-mantissa typedef with its field positions, shared with normalize/round
- One sub-module: fp_align_shifter. Combinational right shifter with sticky collection and saturation at SHIFT_SAT, instantiated in stage 2.

Test Plan:
- ADD 0x3F800000 + 0x3F000000 → after 2 cycles: out_exp=0x7F, mant_a=0x4000000, mant_b=0x2000000, swapped=0, eff_sub=0.
- ADD 0x3F000000 + 0xBF800000 → swapped=1, sign_a=1, sign_b=0, eff_sub=1, mant_b=0x2000000.
- ADD 0x3F800000 + 0x30800000 (d=30) → mant_b=0x0000001. Also d=3 with B=0x3E000001 → GRS and sticky shifted-out bits checked.
- NaN 0x7FC00000 ADD 0x00000001 → class_a=nan, class_b=subnormal; with FP_ALIGN_FTZ_EN, class_b=zero and mant_b=0.
- Backpressure: out_ready=0, stream 4 pairs → exactly 2 accepted, then in_ready=0. Release → results appear in order, one per cycle, stable while stalled.
- Assert rst while both stages are valid → out_valid=0 immediately, all outputs 0, no stale result after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operation and rounding-mode encodings,
// one-hot class bit positions, and the 28-bit extended-mantissa layout used
// between operand alignment and normalize/round.
package fp_pkg;

    typedef enum logic [4:0] {
        FP_ADD  = 5'b00001,
        FP_SUB  = 5'b00010,
        FP_MUL  = 5'b00011,
        FP_DIV  = 5'b00100,
        FP_SQRT = 5'b00101,
        FP_CONV = 5'b01110
    } alu_op_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rm_e;

    // Bit positions inside the one-hot class vector {nan, inf, zero, subnormal}
    localparam int CLS_SUBNORM = 0;
    localparam int CLS_ZERO    = 1;
    localparam int CLS_INF     = 2;
    localparam int CLS_NAN     = 3;

    // Extended-mantissa field positions
    localparam int EXT_W       = 28;
    localparam int EXT_CARRY   = 27;
    localparam int EXT_HIDDEN  = 26;
    localparam int EXT_FRAC_HI = 25;
    localparam int EXT_FRAC_LO = 3;
    localparam int EXT_GUARD   = 2;
    localparam int EXT_ROUND   = 1;
    localparam int EXT_STICKY  = 0;

    typedef struct packed {
        logic        carry;
        logic        hidden;
        logic [22:0] frac;
        logic        guard;
        logic        round;
        logic        sticky;
    } ext_mant_t;

    // Build an unshifted extended mantissa: no carry, empty GRS bits
    function automatic ext_mant_t make_ext(input logic hidden, input logic [22:0] frac);
        ext_mant_t m;
        m.carry  = 1'b0;
        m.hidden = hidden;
        m.frac   = frac;
        m.guard  = 1'b0;
        m.round  = 1'b0;
        m.sticky = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right shifter for the B mantissa. Bits shifted past the
// bottom are folded into the sticky bit; at SHIFT_SAT or beyond, the whole
// operand collapses to a lone sticky bit (or zero if B was zero).
module fp_align_shifter #(
    parameter int SHIFT_SAT = 27
) (
    input  logic [27:0] mant_in,
    input  logic [7:0]  shamt,
    output logic [27:0] mant_out
);

    localparam logic [7:0] SAT = 8'(SHIFT_SAT);

    logic [27:0] shifted;
    logic [27:0] lost_mask;
    logic        lost;

    // Shift, gather discarded bits into sticky, saturate on large distances
    always_comb begin
        shifted   = mant_in >> shamt;
        lost_mask = ~(28'hFFF_FFFF << shamt);
        lost      = |(mant_in & lost_mask);
        if (shamt >= SAT) begin
            mant_out = {27'd0, |mant_in};
        end else begin
            mant_out = {shifted[27:1], shifted[0] | lost};
        end
    end

endmodule

// File: rtl/fp_operand_align_32bit.sv
// FP operand front end: unpack/classify/swap (stage 1), then align B to A's
// exponent (stage 2), with a valid/ready handshake on both sides.
// Optional build macro FP_ALIGN_FTZ_EN flushes subnormal inputs to signed zero.
module fp_operand_align_32bit
    import fp_pkg::*;
#(
    parameter int SHIFT_SAT = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  alu_op,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign_a,
    output logic        out_sign_b,
    output logic [7:0]  out_exp,
    output logic [27:0] out_mant_a,
    output logic [27:0] out_mant_b,
    output logic [3:0]  out_class_a,
    output logic [3:0]  out_class_b,
    output logic        out_swapped,
    output logic        out_eff_sub,
    output logic [4:0]  out_alu_op,
    output logic [2:0]  out_rm
);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp_raw;
        logic [7:0]  exp_eff;
        logic        hidden;
        logic [22:0] frac;
        logic [3:0]  cls;
    } opnd_t;

    typedef struct packed {
        opnd_t       a;
        opnd_t       b;
        logic        addsub;
        logic        swapped;
        logic        eff_sub;
        logic [4:0]  alu_op;
        logic [2:0]  rm;
    } s1_t;

    typedef struct packed {
        logic        sign_a;
        logic        sign_b;
        logic [7:0]  exp;
        logic [27:0] mant_a;
        logic [27:0] mant_b;
        logic [3:0]  cls_a;
        logic [3:0]  cls_b;
        logic        swapped;
        logic        eff_sub;
        logic [4:0]  alu_op;
        logic [2:0]  rm;
    } s2_t;

    // Split an IEEE single into fields and classify it
    function automatic opnd_t unpack(input logic [31:0] x);
        opnd_t o;
        o.sign    = x[31];
        o.exp_raw = x[30:23];
        o.frac    = x[22:0];
        o.hidden  = (x[30:23] != 8'd0);
        o.exp_eff = x[30:23];
        o.cls     = 4'b0000;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] != 23'd0) o.cls[CLS_NAN] = 1'b1;
            else                  o.cls[CLS_INF] = 1'b1;
        end else if (x[30:23] == 8'd0) begin
            if (x[22:0] == 23'd0) begin
                o.cls[CLS_ZERO] = 1'b1;
            end else begin
`ifdef FP_ALIGN_FTZ_EN
                o.frac          = 23'd0;
                o.cls[CLS_ZERO] = 1'b1;
`else
                o.exp_eff          = 8'd1;
                o.cls[CLS_SUBNORM] = 1'b1;
`endif
            end
        end
        return o;
    endfunction

    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    s1_t         s1_q, s1_d, s1_new;
    s2_t         s2_q, s2_d, s2_new;
    logic        s1_free, s2_free;
    opnd_t       ua, ub;
    logic        addsub, swap;
    logic signed [9:0] d;
    logic [7:0]  shamt;
    logic [27:0] mant_b_raw, mant_b_al;

    assign s2_free  = ~s2_valid_q | out_ready;
    assign s1_free  = ~s1_valid_q | s2_free;
    assign in_ready = s1_free;

    // Handshake: each stage advances when its downstream slot is free
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (s1_free) s1_valid_d = in_valid;
        if (s2_free) s2_valid_d = s1_valid_q;
    end

    // ---- stage 1: unpack, classify, SUB sign flip, magnitude swap ----
    always_comb begin
        ua     = unpack(op_a);
        ub     = unpack(op_b);
        addsub = (alu_op == FP_ADD) || (alu_op == FP_SUB);
        if (alu_op == FP_SUB) ub.sign = ~ub.sign;
        swap   = addsub && ({ub.exp_raw, ub.frac} > {ua.exp_raw, ua.frac});
        s1_new.a       = swap ? ub : ua;
        s1_new.b       = swap ? ua : ub;
        s1_new.addsub  = addsub;
        s1_new.swapped = swap;
        s1_new.eff_sub = addsub & (ua.sign ^ ub.sign);
        s1_new.alu_op  = alu_op;
        s1_new.rm      = rm;
        s1_d = s1_q;
        if (s1_free && in_valid) s1_d = s1_new;
    end

    // ---- stage 2: exponent difference and B alignment ----
    assign d          = $signed({2'b00, s1_q.a.exp_eff}) - $signed({2'b00, s1_q.b.exp_eff});
    assign shamt      = (s1_q.addsub && (d > 10'sd0)) ? d[7:0] : 8'd0;
    assign mant_b_raw = make_ext(s1_q.b.hidden, s1_q.b.frac);

    fp_align_shifter #(
        .SHIFT_SAT (SHIFT_SAT)
    ) u_shifter (
        .mant_in  (mant_b_raw),
        .shamt    (shamt),
        .mant_out (mant_b_al)
    );

    // Assemble the aligned result and hold it while downstream stalls
    always_comb begin
        s2_new.sign_a  = s1_q.a.sign;
        s2_new.sign_b  = s1_q.b.sign;
        s2_new.exp     = s1_q.addsub ? s1_q.a.exp_eff : s1_q.a.exp_raw;
        s2_new.mant_a  = make_ext(s1_q.a.hidden, s1_q.a.frac);
        s2_new.mant_b  = mant_b_al;
        s2_new.cls_a   = s1_q.a.cls;
        s2_new.cls_b   = s1_q.b.cls;
        s2_new.swapped = s1_q.swapped;
        s2_new.eff_sub = s1_q.eff_sub;
        s2_new.alu_op  = s1_q.alu_op;
        s2_new.rm      = s1_q.rm;
        s2_d = s2_q;
        if (s2_free && s1_valid_q) s2_d = s2_new;
    end

    // Control and output registers; outputs read zero while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    // Stage-1 payload is qualified by s1_valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        s1_q <= s1_d;
    end

    assign out_valid   = s2_valid_q;
    assign out_sign_a  = s2_q.sign_a;
    assign out_sign_b  = s2_q.sign_b;
    assign out_exp     = s2_q.exp;
    assign out_mant_a  = s2_q.mant_a;
    assign out_mant_b  = s2_q.mant_b;
    assign out_class_a = s2_q.cls_a;
    assign out_class_b = s2_q.cls_b;
    assign out_swapped = s2_q.swapped;
    assign out_eff_sub = s2_q.eff_sub;
    assign out_alu_op  = s2_q.alu_op;
    assign out_rm      = s2_q.rm;

endmodule

// File: tb/tb_fp_operand_align_32bit.sv
// Directed bench for fp_operand_align_32bit: vector table streamed at full
// rate, then backpressure and mid-flight reset sequences.
module tb_fp_operand_align_32bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic [4:0]  alu_op;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign_a, out_sign_b;
    logic [7:0]  out_exp;
    logic [27:0] out_mant_a, out_mant_b;
    logic [3:0]  out_class_a, out_class_b;
    logic        out_swapped, out_eff_sub;
    logic [4:0]  out_alu_op;
    logic [2:0]  out_rm;

    fp_operand_align_32bit #(.SHIFT_SAT(27)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign_a(out_sign_a), .out_sign_b(out_sign_b), .out_exp(out_exp),
        .out_mant_a(out_mant_a), .out_mant_b(out_mant_b),
        .out_class_a(out_class_a), .out_class_b(out_class_b),
        .out_swapped(out_swapped), .out_eff_sub(out_eff_sub),
        .out_alu_op(out_alu_op), .out_rm(out_rm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic [2:0]  rm;
        logic        sa, sb;
        logic [7:0]  e;
        logic [27:0] ma, mb;
        logic [3:0]  ca, cb;
        logic        sw, es;
    } vec_t;

    localparam int NV = 16;
    vec_t tv [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] r, input logic sa, input logic sb, input logic [7:0] e,
                                input logic [27:0] ma, input logic [27:0] mb, input logic [3:0] ca,
                                input logic [3:0] cb, input logic sw, input logic es);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rm = r; v.sa = sa; v.sb = sb; v.e = e;
        v.ma = ma; v.mb = mb; v.ca = ca; v.cb = cb; v.sw = sw; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        chk({p, "_valid"},   32'(out_valid),   32'd1);
        chk({p, "_sign_a"},  32'(out_sign_a),  32'(v.sa));
        chk({p, "_sign_b"},  32'(out_sign_b),  32'(v.sb));
        chk({p, "_exp"},     32'(out_exp),     32'(v.e));
        chk({p, "_mant_a"},  32'(out_mant_a),  32'(v.ma));
        chk({p, "_mant_b"},  32'(out_mant_b),  32'(v.mb));
        chk({p, "_class_a"}, 32'(out_class_a), 32'(v.ca));
        chk({p, "_class_b"}, 32'(out_class_b), 32'(v.cb));
        chk({p, "_swapped"}, 32'(out_swapped), 32'(v.sw));
        chk({p, "_eff_sub"}, 32'(out_eff_sub), 32'(v.es));
        chk({p, "_alu_op"},  32'(out_alu_op),  32'(v.op));
        chk({p, "_rm"},      32'(out_rm),      32'(v.rm));
    endtask

    task automatic drive(input vec_t v);
        op_a     = v.a;
        op_b     = v.b;
        alu_op   = v.op;
        rm       = v.rm;
        in_valid = 1'b1;
    endtask

    task automatic chk_zero_outputs(input string p);
        chk({p, "_out_valid"}, 32'(out_valid),   32'd0);
        chk({p, "_sign_a"},    32'(out_sign_a),  32'd0);
        chk({p, "_exp"},       32'(out_exp),     32'd0);
        chk({p, "_mant_a"},    32'(out_mant_a),  32'd0);
        chk({p, "_mant_b"},    32'(out_mant_b),  32'd0);
        chk({p, "_class_b"},   32'(out_class_b), 32'd0);
        chk({p, "_alu_op"},    32'(out_alu_op),  32'd0);
        chk({p, "_rm"},        32'(out_rm),      32'd0);
    endtask

    initial begin
        int k;
        int acc;
        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; alu_op = '0; rm = '0;
        out_ready = 1'b1;

        //          op     a             b             rm sa sb e      ma            mb            ca    cb    sw es
        tv[0]  = mk(5'd1, 32'h3F800000, 32'h3F000000, 3'd0, 0, 0, 8'h7F, 28'h4000000, 28'h2000000, 4'h0, 4'h0, 0, 0);
        tv[1]  = mk(5'd1, 32'h3F000000, 32'hBF800000, 3'd1, 1, 0, 8'h7F, 28'h4000000, 28'h2000000, 4'h0, 4'h0, 1, 1);
        tv[2]  = mk(5'd1, 32'h3F800000, 32'h30800000, 3'd2, 0, 0, 8'h7F, 28'h4000000, 28'h0000001, 4'h0, 4'h0, 0, 0);
        tv[3]  = mk(5'd1, 32'h3F800000, 32'h3E000001, 3'd3, 0, 0, 8'h7F, 28'h4000000, 28'h0800001, 4'h0, 4'h0, 0, 0);
        tv[4]  = mk(5'd1, 32'h3F800000, 32'h3D800001, 3'd4, 0, 0, 8'h7F, 28'h4000000, 28'h0400001, 4'h0, 4'h0, 0, 0);
        tv[5]  = mk(5'd1, 32'h3F800000, 32'h33400000, 3'd0, 0, 0, 8'h7F, 28'h4000000, 28'h0000003, 4'h0, 4'h0, 0, 0);
        tv[6]  = mk(5'd1, 32'h3F800000, 32'h32000000, 3'd1, 0, 0, 8'h7F, 28'h4000000, 28'h0000001, 4'h0, 4'h0, 0, 0);
        tv[7]  = mk(5'd1, 32'h3F800000, 32'h00000000, 3'd2, 0, 0, 8'h7F, 28'h4000000, 28'h0000000, 4'h0, 4'h2, 0, 0);
        tv[8]  = mk(5'd2, 32'h3F800000, 32'h3F800000, 3'd3, 0, 1, 8'h7F, 28'h4000000, 28'h4000000, 4'h0, 4'h0, 0, 1);
        tv[9]  = mk(5'd2, 32'h3F800000, 32'h40000000, 3'd4, 1, 0, 8'h80, 28'h4000000, 28'h2000000, 4'h0, 4'h0, 1, 1);
        tv[10] = mk(5'd3, 32'h3F000000, 32'h40400000, 3'd0, 0, 0, 8'h7E, 28'h4000000, 28'h6000000, 4'h0, 4'h0, 0, 0);
        tv[11] = mk(5'd4, 32'hC0000000, 32'h3F800000, 3'd1, 1, 0, 8'h80, 28'h4000000, 28'h4000000, 4'h0, 4'h0, 0, 0);
        tv[12] = mk(5'd1, 32'h7F800000, 32'h3F800000, 3'd2, 0, 0, 8'hFF, 28'h4000000, 28'h0000001, 4'h4, 4'h0, 0, 0);
`ifdef FP_ALIGN_FTZ_EN
        tv[13] = mk(5'd1, 32'h7FC00000, 32'h00000001, 3'd3, 0, 0, 8'hFF, 28'h6000000, 28'h0000000, 4'h8, 4'h2, 0, 0);
        tv[14] = mk(5'd1, 32'h00000003, 32'h00800000, 3'd4, 0, 0, 8'h01, 28'h4000000, 28'h0000000, 4'h0, 4'h2, 1, 0);
`else
        tv[13] = mk(5'd1, 32'h7FC00000, 32'h00000001, 3'd3, 0, 0, 8'hFF, 28'h6000000, 28'h0000001, 4'h8, 4'h1, 0, 0);
        tv[14] = mk(5'd1, 32'h00000003, 32'h00800000, 3'd4, 0, 0, 8'h01, 28'h4000000, 28'h0000018, 4'h0, 4'h1, 1, 0);
`endif
        tv[15] = mk(5'd5, 32'h40800000, 32'hFFFFFFFF, 3'd0, 0, 1, 8'h81, 28'h4000000, 28'h7FFFFF8, 4'h0, 4'h8, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Table streamed one pair per cycle; each result due exactly 2 cycles later
        k = 0;
        for (int cyc = 0; cyc < NV + 3; cyc++) begin
            if (out_valid) begin
                if (k < NV) begin
                    chk($sformatf("v%0d_latency", k), 32'(cyc), 32'(k + 2));
                    check_vec(tv[k], k);
                end
                k++;
            end
            if (cyc < NV) drive(tv[cyc]);
            else          in_valid = 1'b0;
            @(negedge clk);
        end
        chk("table_result_count", 32'(k), 32'(NV));

        // Backpressure: with out_ready low only two pairs fit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(tv[acc]);
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("bp_hold%0d_valid", j), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_mant_b", j), 32'(out_mant_b), 32'(tv[0].mb));
            chk($sformatf("bp_hold%0d_rm", j), 32'(out_rm), 32'(tv[0].rm));
            @(negedge clk);
        end
        check_vec(tv[0], 100);
        out_ready = 1'b1;
        @(negedge clk);
        check_vec(tv[1], 101);
        @(negedge clk);
        chk("bp_drained_valid", 32'(out_valid), 32'd0);

        // Reset while both stages hold a pair
        out_ready = 1'b0;
        drive(tv[2]);
        @(negedge clk);
        drive(tv[3]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_full_valid", 32'(out_valid), 32'd1);
        chk("midrst_full_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk_zero_outputs("midrst");
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_stale%0d", j), 32'(out_valid), 32'd0);
        end
        drive(tv[9]);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check_vec(tv[9], 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
